// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : stopwatch_pkg                                               |
// | Description: Shared types and constants for the stopwatch datapath:      |
// |              packed BCD time word, lap controller state encoding and     |
// |              the tick rate of the timebase.                              |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package stopwatch_pkg;

  // Eight packed BCD digits, most significant first: HH:MM:SS.cc
  typedef struct packed {
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] cseg1;
    logic [3:0] cseg0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    HOLD   = 2'd1,
    RECALL = 2'd2
  } lap_state_e;

  localparam int TICK_HZ = 100;

endpackage
`default_nettype wire

// File: rtl/lap_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : lap_mem                                                     |
// | Description: DEPTH x 32 lap register file, one synchronous write port    |
// |              and one combinational read port. Storage is not reset.      |
// | Ports      : clk      - system clock                                     |
// |              we_i     - write enable                                     |
// |              waddr_i  - write address                                    |
// |              wdata_i  - write data (packed BCD time)                     |
// |              raddr_i  - read address                                     |
// |              rdata_o  - read data, combinational                         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module lap_mem
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  bcd_time_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/lap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : lap_ctrl                                                    |
// | Description: Lap/split controller. Captures lap times into a circular    |
// |              store, freezes the display for HOLD_TICKS ticks after each  |
// |              capture, and lets the user browse stored laps newest-first  |
// |              while the watch is stopped.                                 |
// | Ports      : clk       - system clock                                    |
// |              rst       - asynchronous reset, active low                  |
// |              tick_i    - 100 Hz enable pulse                             |
// |              run_i     - stopwatch running                               |
// |              lap_i     - lap request pulse                               |
// |              recall_i  - browse request pulse                            |
// |              clear_i   - clear lap memory pulse                          |
// |              time_i    - live BCD time                                   |
// |              time_o    - BCD time to display                             |
// |              lap_num_o - shown lap number, 0 for live time               |
// |              count_o   - number of stored laps (saturating)              |
// |              frozen_o  - display frozen (HOLD or RECALL)                 |
// |              full_o    - store holds DEPTH laps                          |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int HOLD_TICKS = 200,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int AW        = $clog2(DEPTH),
  localparam int HW        = $clog2(HOLD_TICKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic          run_i,
  input  logic          lap_i,
  input  logic          recall_i,
  input  logic          clear_i,
  input  logic [31:0]   time_i,
  output logic [31:0]   time_o,
  output logic [CW-1:0] lap_num_o,
  output logic [CW-1:0] count_o,
  output logic          frozen_o,
  output logic          full_o
);

  lap_state_e    state_q,   state_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ofs_q,  rd_ofs_d;
  logic [CW-1:0] count_q,   count_d;
  logic [HW-1:0] hold_q,    hold_d;
  bcd_time_t     time_q,    time_d;
  logic [CW-1:0] lap_num_q, lap_num_d;
  logic          frozen_q,  frozen_d;
  logic          full_q,    full_d;

  logic          mem_we;
  logic [AW-1:0] rd_ofs_nxt;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;

  // Offset the read port points at for the entry shown next cycle:
  // entering RECALL shows the newest entry, each further recall steps back.
  assign rd_ofs_nxt = (state_q == RECALL) ? rd_ofs_q + AW'(1) : '0;
  assign rd_addr    = wr_ptr_q - AW'(1) - rd_ofs_nxt;

  lap_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (time_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ofs_d  = rd_ofs_q;
    count_d   = count_q;
    hold_d    = hold_q;
    time_d    = time_q;
    lap_num_d = lap_num_q;
    frozen_d  = frozen_q;
    mem_we    = 1'b0;

    // Priority chain: clear > lap > recall > hold expiry; losers are dropped.
    if (clear_i && !run_i) begin
      state_d  = LIVE;
      wr_ptr_d = '0;
      rd_ofs_d = '0;
      count_d  = '0;
      hold_d   = '0;
    end else if (lap_i && run_i && (state_q != RECALL)) begin
      mem_we    = 1'b1;
      wr_ptr_d  = wr_ptr_q + AW'(1);
      count_d   = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
      time_d    = time_i;
      lap_num_d = count_d;
      frozen_d  = 1'b1;
      hold_d    = HW'(HOLD_TICKS);
      state_d   = HOLD;
    end else if (recall_i && !run_i && (count_q != '0) && (state_q != RECALL)) begin
      state_d   = RECALL;
      rd_ofs_d  = '0;
      hold_d    = '0;
      time_d    = rd_data;
      lap_num_d = count_q;
      frozen_d  = 1'b1;
    end else if (state_q == RECALL) begin
      if (run_i) begin
        state_d = LIVE;
      end else if (recall_i) begin
        if (CW'(rd_ofs_q) + CW'(1) == count_q) begin
          state_d = LIVE;
        end else begin
          rd_ofs_d  = rd_ofs_nxt;
          time_d    = rd_data;
          lap_num_d = count_q - CW'(rd_ofs_nxt);
        end
      end
    end else if ((state_q == HOLD) && tick_i) begin
      hold_d = hold_q - HW'(1);
      if (hold_q == HW'(1)) begin
        state_d = LIVE;
      end
    end

    // Live display tracks the counter with one cycle of lag.
    if (state_d == LIVE) begin
      time_d    = time_i;
      lap_num_d = '0;
      frozen_d  = 1'b0;
      rd_ofs_d  = '0;
    end

    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LIVE;
      wr_ptr_q  <= '0;
      rd_ofs_q  <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      time_q    <= '0;
      lap_num_q <= '0;
      frozen_q  <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ofs_q  <= rd_ofs_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      time_q    <= time_d;
      lap_num_q <= lap_num_d;
      frozen_q  <= frozen_d;
      full_q    <= full_d;
    end
  end

  assign time_o    = time_q;
  assign lap_num_o = lap_num_q;
  assign count_o   = count_q;
  assign frozen_o  = frozen_q;
  assign full_o    = full_q;

endmodule
`default_nettype wire

// File: tb/tb_lap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_lap_ctrl                                                 |
// | Description: Self-checking bench for lap_ctrl: a table of directed       |
// |              per-cycle vectors plus hand-written multi-cycle sequences   |
// |              for hold duration, recall exit and mid-hold reset.          |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_lap_ctrl;

  logic        clk;
  logic        rst;
  logic        tick_i;
  logic        run_i;
  logic        lap_i;
  logic        recall_i;
  logic        clear_i;
  logic [31:0] time_i;
  logic [31:0] time_o;
  logic [3:0]  lap_num_o;
  logic [3:0]  count_o;
  logic        frozen_o;
  logic        full_o;

  int n_vec = 0;
  int n_err = 0;

  lap_ctrl #(
    .DEPTH      (8),
    .HOLD_TICKS (200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_i    (tick_i),
    .run_i     (run_i),
    .lap_i     (lap_i),
    .recall_i  (recall_i),
    .clear_i   (clear_i),
    .time_i    (time_i),
    .time_o    (time_o),
    .lap_num_o (lap_num_o),
    .count_o   (count_o),
    .frozen_o  (frozen_o),
    .full_o    (full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        tick;
    logic        lap;
    logic        rec;
    logic        clr;
    logic [31:0] tin;
    logic [31:0] etime;
    logic [3:0]  elap;
    logic [3:0]  ecnt;
    logic        efrz;
    logic        efull;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, t, l, rc, c, input logic [31:0] tin,
                     input logic [31:0] et, input int el, input int ec,
                     input logic ef, input logic efu);
    vec_t v;
    v.run = r; v.tick = t; v.lap = l; v.rec = rc; v.clr = c; v.tin = tin;
    v.etime = et; v.elap = 4'(el); v.ecnt = 4'(ec); v.efrz = ef; v.efull = efu;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] et, input int el,
                       input int ec, input logic ef, input logic efu);
    n_vec++;
    if (time_o !== et || lap_num_o !== 4'(el) || count_o !== 4'(ec) ||
        frozen_o !== ef || full_o !== efu) begin
      n_err++;
      $display("FAIL %s: got time_o=%h lap=%0d cnt=%0d frz=%b full=%b, want time_o=%h lap=%0d cnt=%0d frz=%b full=%b",
               name, time_o, lap_num_o, count_o, frozen_o, full_o, et, el, ec, ef, efu);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, then drop the pulses.
  task automatic apply(input logic r, t, l, rc, c, input logic [31:0] tin);
    run_i = r; tick_i = t; lap_i = l; recall_i = rc; clear_i = c; time_i = tin;
    @(posedge clk);
    #1;
    tick_i = 1'b0; lap_i = 1'b0; recall_i = 1'b0; clear_i = 1'b0;
  endtask

  initial begin
    logic [31:0] tl;
    rst = 1'b0; run_i = 1'b0; tick_i = 1'b0; lap_i = 1'b0;
    recall_i = 1'b0; clear_i = 1'b0; time_i = 32'h0000_4321;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'h0, 0, 0, 1'b0, 1'b0);
    rst = 1'b1;

    // ---------------- vector table ----------------
    add(1, 0, 0, 0, 0, 32'h0000_1234, 32'h0000_1234, 0, 0, 1'b0, 1'b0);
    // Nine back-to-back laps, lap k captures 00:00:01.0k
    for (int k = 1; k <= 9; k++) begin
      tl = 32'h0000_0100 + 32'(k);
      add(1, 0, 1, 0, 0, tl, tl, (k > 8) ? 8 : k, (k > 8) ? 8 : k, 1'b1, k >= 8);
    end
    // Stop: still holding the ninth lap
    add(0, 0, 0, 0, 0, 32'h0000_5999, 32'h0000_0109, 8, 8, 1'b1, 1'b1);
    // Eight recalls: lap 9 (shown #8) down to lap 2 (shown #1)
    for (int j = 0; j < 8; j++) begin
      tl = 32'h0000_0109 - 32'(j);
      add(0, 0, 0, 1, 0, 32'h0000_5999, tl, 8 - j, 8, 1'b1, 1'b1);
    end
    // Ninth recall returns to live
    add(0, 0, 0, 1, 0, 32'h0000_5999, 32'h0000_5999, 0, 8, 1'b0, 1'b1);
    // clear + lap + recall together while stopped: clear wins
    add(0, 0, 1, 1, 1, 32'h0000_6000, 32'h0000_6000, 0, 0, 1'b0, 1'b0);
    // recall with empty store is ignored
    add(0, 0, 0, 1, 0, 32'h0000_6001, 32'h0000_6001, 0, 0, 1'b0, 1'b0);
    // lap while stopped is ignored
    add(0, 0, 1, 0, 0, 32'h0000_6002, 32'h0000_6002, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].run, vecs[i].tick, vecs[i].lap, vecs[i].rec, vecs[i].clr, vecs[i].tin);
      check($sformatf("vec%0d", i), vecs[i].etime, vecs[i].elap, vecs[i].ecnt,
            vecs[i].efrz, vecs[i].efull);
    end

    // ---------------- hold lasts exactly 200 ticks ----------------
    apply(1, 0, 0, 0, 0, 32'h0000_1234);
    check("live_track", 32'h0000_1234, 0, 0, 1'b0, 1'b0);
    apply(1, 0, 1, 0, 0, 32'h0000_1234);
    check("lap_capture", 32'h0000_1234, 1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 199; i++) apply(1, 1, 0, 0, 0, 32'h0000_5678);
    check("hold_199", 32'h0000_1234, 1, 1, 1'b1, 1'b0);
    apply(1, 1, 0, 0, 0, 32'h0000_5678);
    check("hold_expire", 32'h0000_5678, 0, 1, 1'b0, 1'b0);

    // ---------------- recall exited by run_i ----------------
    apply(0, 0, 0, 1, 0, 32'h0000_5678);
    check("recall_one", 32'h0000_1234, 1, 1, 1'b1, 1'b0);
    apply(1, 0, 0, 1, 0, 32'h0000_7777);
    check("recall_run_exit", 32'h0000_7777, 0, 1, 1'b0, 1'b0);
    apply(1, 0, 0, 1, 0, 32'h0000_8888);
    check("recall_while_run", 32'h0000_8888, 0, 1, 1'b0, 1'b0);

    // ---------------- reset mid-hold, 50 ticks left ----------------
    apply(1, 0, 1, 0, 0, 32'h0000_2000);
    check("lap_second", 32'h0000_2000, 2, 2, 1'b1, 1'b0);
    for (int i = 0; i < 150; i++) apply(1, 1, 0, 0, 0, 32'h0000_2100);
    check("hold_150", 32'h0000_2000, 2, 2, 1'b1, 1'b0);
    rst = 1'b0;
    #2;
    check("async_reset", 32'h0, 0, 0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 60; i++) apply(1, 1, 0, 0, 0, 32'h0000_3000);
    check("post_reset_live", 32'h0000_3000, 0, 0, 1'b0, 1'b0);
    apply(1, 0, 1, 0, 0, 32'h0000_3001);
    check("post_reset_lap", 32'h0000_3001, 1, 1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
